// File: rtl/filter_stream_sequencer_pkg.sv
// Shared definitions for the filter stream sequencer: state encoding,
// default pipeline latencies and a width helper for the board top level.
package filter_stream_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int DEF_ROM_LAT  = 1;
    localparam int DEF_FILT_LAT = 1;

    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/filter_stream_sequencer_edge_detect.sv
// Rising-edge detector for debounced button levels. The history register
// resets high so a level held through reset does not produce an edge.
module filter_stream_sequencer_edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_level,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_prev;

    // Previous-level history for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= '1;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/filter_stream_sequencer.sv
// Single-clock run controller: clears the filter, streams ROM samples into it,
// writes latency-aligned results to the capture RAM and keeps a readout address.
module filter_stream_sequencer
    import filter_stream_sequencer_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int ADDR_BITS   = 8,
    parameter int NUM_SAMPLES = 255,
    parameter int ROM_LAT     = DEF_ROM_LAT,
    parameter int FILT_LAT    = DEF_FILT_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 step_up,
    input  logic                 step_down,
    output logic [ADDR_BITS-1:0] o_rom_addr,
    input  logic [DATA_BITS-1:0] i_rom_data,
    output logic                 o_filt_clr,
    output logic                 o_filt_en,
    output logic [DATA_BITS-1:0] o_filt_in,
    input  logic [DATA_BITS-1:0] i_filt_out,
    output logic                 o_ram_we,
    output logic [ADDR_BITS-1:0] o_ram_waddr,
    output logic [DATA_BITS-1:0] o_ram_wdata,
    output logic [ADDR_BITS-1:0] o_rd_addr,
    output logic                 busy,
    output logic                 done
);

    localparam int PIPE = ROM_LAT + FILT_LAT;
    localparam int CW   = ADDR_BITS + 1;
    localparam logic [CW-1:0]        LAST_CNT  = CW'(NUM_SAMPLES - 1);
    localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_SAMPLES - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

    logic [2:0]           w_rise;
    state_e               r_state;
    state_e               w_next;
    logic [CW-1:0]        r_rd_cnt;
    logic [CW-1:0]        r_wr_cnt;
    logic [PIPE-1:0]      r_vld;
    logic                 r_cont;
    logic                 r_filt_clr;
    logic                 r_busy;
    logic                 r_done;
    logic [DATA_BITS-1:0] r_filt_in;
    logic [ADDR_BITS-1:0] r_rd_addr;
    logic                 w_last_issue;
    logic                 w_last_write;

    filter_stream_sequencer_edge_detect #(.WIDTH(3)) u_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level ({step_down, step_up, start}),
        .o_rise  (w_rise)
    );

    assign w_last_issue = (r_rd_cnt == LAST_CNT);
    assign w_last_write = r_vld[PIPE-1] && (r_wr_cnt == LAST_CNT);

    // Next-state decode; start edges outside IDLE/DONE are dropped
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise[0]) w_next = ST_CLEAR;
                else           w_next = ST_IDLE;
            end
            ST_CLEAR: w_next = ST_RUN;
            ST_RUN: begin
                if (w_last_issue) w_next = ST_FLUSH;
                else              w_next = ST_RUN;
            end
            ST_FLUSH: begin
                if (w_last_write) w_next = ST_DONE;
                else              w_next = ST_FLUSH;
            end
            ST_DONE: begin
                if (r_cont || w_rise[0]) w_next = ST_CLEAR;
                else                     w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, status strobes, counters and the issue-tracking valid pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_filt_clr <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cont     <= 1'b0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_vld      <= '0;
            r_filt_in  <= '0;
        end else begin
            r_state    <= w_next;
            r_filt_clr <= (w_next == ST_CLEAR);
            r_busy     <= (w_next == ST_CLEAR) || (w_next == ST_RUN) || (w_next == ST_FLUSH);
            r_done     <= (w_next == ST_DONE);
            if ((w_next == ST_DONE) && (r_state != ST_DONE)) r_cont <= continuous;
            else                                             r_cont <= r_cont;
            if (r_state == ST_CLEAR)    r_rd_cnt <= '0;
            else if (r_state == ST_RUN) r_rd_cnt <= r_rd_cnt + CNT_ONE;
            else                        r_rd_cnt <= r_rd_cnt;
            // Valid bit k is the issue from k+1 cycles ago
            r_vld <= {r_vld[PIPE-2:0], (r_state == ST_RUN)};
            if (r_state == ST_CLEAR)  r_wr_cnt <= '0;
            else if (r_vld[PIPE-1])   r_wr_cnt <= r_wr_cnt + CNT_ONE;
            else                      r_wr_cnt <= r_wr_cnt;
            if (r_vld[ROM_LAT-1]) r_filt_in <= i_rom_data;
            else                  r_filt_in <= r_filt_in;
        end
    end

    // Readout address stepping with wrap over the sample range
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_addr <= '0;
        end else if (w_rise[1] && !w_rise[2]) begin
            r_rd_addr <= (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + ADDR_ONE;
        end else if (w_rise[2] && !w_rise[1]) begin
            r_rd_addr <= (r_rd_addr == '0) ? LAST_ADDR : r_rd_addr - ADDR_ONE;
        end else begin
            r_rd_addr <= r_rd_addr;
        end
    end

    assign o_rom_addr  = r_rd_cnt[ADDR_BITS-1:0];
    assign o_filt_clr  = r_filt_clr;
    assign o_filt_en   = r_vld[ROM_LAT-1];
    assign o_filt_in   = r_filt_in;
    assign o_ram_we    = r_vld[PIPE-1];
    assign o_ram_waddr = r_wr_cnt[ADDR_BITS-1:0];
    assign o_ram_wdata = r_vld[PIPE-1] ? i_filt_out : '0;
    assign o_rd_addr   = r_rd_addr;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_filter_stream_sequencer.sv
// Bench for filter_stream_sequencer: two instances (default latencies and a
// long-latency short run) against a ROM/median-filter environment and a scoreboard.
module tb_filter_stream_sequencer;

    logic       clk;
    logic       rst;
    logic       step_up;
    logic       step_down;
    logic       start_s   [2];
    logic       cont_s    [2];
    logic [7:0] rom_addr_s[2];
    logic [7:0] rom_data_s[2];
    logic       clr_s     [2];
    logic       en_s      [2];
    logic [7:0] filt_in_s [2];
    logic [7:0] filt_out_s[2];
    logic       we_s      [2];
    logic [7:0] waddr_s   [2];
    logic [7:0] wdata_s   [2];
    logic [7:0] rd_addr_s [2];
    logic       busy_s    [2];
    logic       done_s    [2];

    int nsmp[2] = '{255, 16};
    int rlat[2] = '{1, 2};
    int flat[2] = '{1, 5};
    int rd_model[2];
    int n_checks;
    int n_pass;

    logic [7:0] rom[256];
    logic [7:0] romq_a, romq_b1, romq_b2;
    logic [7:0] wa0, wa1, wb0, wb1, res_a;
    logic [7:0] pb[5];

    filter_stream_sequencer u_dut_a (
        .clk(clk), .rst(rst), .start(start_s[0]), .continuous(cont_s[0]),
        .step_up(step_up), .step_down(step_down),
        .o_rom_addr(rom_addr_s[0]), .i_rom_data(rom_data_s[0]),
        .o_filt_clr(clr_s[0]), .o_filt_en(en_s[0]), .o_filt_in(filt_in_s[0]),
        .i_filt_out(filt_out_s[0]), .o_ram_we(we_s[0]), .o_ram_waddr(waddr_s[0]),
        .o_ram_wdata(wdata_s[0]), .o_rd_addr(rd_addr_s[0]), .busy(busy_s[0]), .done(done_s[0])
    );

    filter_stream_sequencer #(.NUM_SAMPLES(16), .ROM_LAT(2), .FILT_LAT(5)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_s[1]), .continuous(cont_s[1]),
        .step_up(step_up), .step_down(step_down),
        .o_rom_addr(rom_addr_s[1]), .i_rom_data(rom_data_s[1]),
        .o_filt_clr(clr_s[1]), .o_filt_en(en_s[1]), .o_filt_in(filt_in_s[1]),
        .i_filt_out(filt_out_s[1]), .o_ram_we(we_s[1]), .o_ram_waddr(waddr_s[1]),
        .o_ram_wdata(wdata_s[1]), .o_rd_addr(rd_addr_s[1]), .busy(busy_s[1]), .done(done_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] lo, hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c <= lo) return lo;
        if (c >= hi) return hi;
        return c;
    endfunction

    function automatic logic [7:0] sample(input int k);
        return (k < 0) ? 8'd0 : rom[k];
    endfunction

    // Expected filter result for sample k of a run (window cleared at run start)
    function automatic logic [7:0] exp_out(input int k);
        return med3(sample(k), sample(k - 1), sample(k - 2));
    endfunction

    // Environment: ROMs with ROM_LAT latency, median-of-3 filters with FILT_LAT latency
    always @(posedge clk) begin
        romq_a  <= rom[rom_addr_s[0]];
        romq_b1 <= rom[rom_addr_s[1]];
        romq_b2 <= romq_b1;
        if (clr_s[0]) begin
            wa0 <= 8'd0; wa1 <= 8'd0;
        end else if (en_s[0]) begin
            res_a <= med3(rom_data_s[0], wa0, wa1);
            wa1 <= wa0; wa0 <= rom_data_s[0];
        end
        if (clr_s[1]) begin
            wb0 <= 8'd0; wb1 <= 8'd0;
        end else if (en_s[1]) begin
            pb[0] <= med3(rom_data_s[1], wb0, wb1);
            wb1 <= wb0; wb0 <= rom_data_s[1];
        end
        for (int i = 1; i < 5; i++) pb[i] <= pb[i-1];
    end

    assign rom_data_s[0] = romq_a;
    assign rom_data_s[1] = romq_b2;
    assign filt_out_s[0] = res_a;
    assign filt_out_s[1] = pb[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_zero(input int d);
        chk("rst_rom_addr", rom_addr_s[d], 0);
        chk("rst_filt_clr", clr_s[d], 0);
        chk("rst_filt_en", en_s[d], 0);
        chk("rst_filt_in", filt_in_s[d], 0);
        chk("rst_ram_we", we_s[d], 0);
        chk("rst_waddr", waddr_s[d], 0);
        chk("rst_wdata", wdata_s[d], 0);
        chk("rst_rd_addr", rd_addr_s[d], 0);
        chk("rst_busy", busy_s[d], 0);
        chk("rst_done", done_s[d], 0);
    endtask

    // One step-button action, then release; both instances follow the wrap model
    task automatic step(input logic up, input logic dn);
        step_up = up; step_down = dn;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (up && !dn) rd_model[d] = (rd_model[d] + 1) % nsmp[d];
            if (dn && !up) rd_model[d] = (rd_model[d] + nsmp[d] - 1) % nsmp[d];
            chk("rd_addr_step", rd_addr_s[d], rd_model[d]);
        end
        step_up = 1'b0; step_down = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("rd_addr_hold", rd_addr_s[d], rd_model[d]);
    endtask

    // Called at the negedge of cycle 0 (start edge or DONE with continuous); checks every cycle to DONE
    task automatic check_run(input int d, input bit poke);
        int n, rl, pipe, tend, k;
        bit we_exp;
        n = nsmp[d]; rl = rlat[d]; pipe = rl + flat[d]; tend = 2 + n + pipe;
        for (int t = 1; t <= tend; t++) begin
            @(negedge clk);
            chk("filt_clr", clr_s[d], t == 1);
            chk("busy", busy_s[d], t < tend);
            chk("done", done_s[d], t == tend);
            if (t >= 2 && t < 2 + n) chk("rom_addr", rom_addr_s[d], t - 2);
            chk("filt_en", en_s[d], (t >= 2 + rl) && (t < 2 + rl + n));
            if (t >= 3 + rl && t <= 2 + rl + n) chk("filt_in", filt_in_s[d], rom[t - 3 - rl]);
            we_exp = (t >= 2 + pipe) && (t < 2 + pipe + n);
            chk("ram_we", we_s[d], we_exp);
            if (we_exp) begin
                k = t - 2 - pipe;
                chk("ram_waddr", waddr_s[d], k);
                chk("ram_wdata", wdata_s[d], exp_out(k));
            end
            chk("rd_addr_run", rd_addr_s[d], rd_model[d]);
            if (poke && t == 50) start_s[d] = 1'b0;
            if (poke && t == 60) start_s[d] = 1'b1;
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b0; step_up = 1'b0; step_down = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; cont_s[d] = 1'b0; rd_model[d] = 0;
        end
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(255, 0));

        // Reset state
        repeat (3) @(negedge clk);
        chk_zero(0);
        chk_zero(1);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy_s[0], 0);

        // Readout stepping: wrap down, full circle up, simultaneous edges
        step(1'b0, 1'b1);
        for (int i = 0; i < 255; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);

        // Default run with an ignored start edge mid-RUN
        start_s[0] = 1'b1;
        check_run(0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("held_done", done_s[0], 1);
            chk("held_we", we_s[0], 0);
        end

        // Long-latency instance, continuous restart, then continuous cleared
        cont_s[1] = 1'b1;
        start_s[1] = 1'b1;
        check_run(1, 1'b0);
        cont_s[1] = 1'b0;
        check_run(1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("stop_done", done_s[1], 1);
            chk("stop_busy", busy_s[1], 0);
            chk("stop_clr", clr_s[1], 0);
        end

        // Reset mid-RUN at sample 100 with start held high through release
        start_s[0] = 1'b0;
        @(negedge clk);
        start_s[0] = 1'b1;
        repeat (102) @(negedge clk);
        chk("pre_rst_addr", rom_addr_s[0], 100);
        chk("pre_rst_we", we_s[0], 1);
        rst = 1'b0;
        #1;
        chk_zero(0);
        chk_zero(1);
        rd_model[0] = 0; rd_model[1] = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            chk("post_rst_we", we_s[0], 0);
            chk("post_rst_busy", busy_s[0], 0);
        end
        start_s[0] = 1'b0;
        @(negedge clk);
        start_s[0] = 1'b1;
        check_run(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/filter_stream_sequencer.md
# filter_stream_sequencer

Synchronous run controller for the masked rank-order filter demo datapath, replacing the gated-clock ROM/RAM sequencing with a single-clock, enable-based stream engine. On a start request it clears the filter window, streams a configurable number of samples from the sample ROM into the filter, aligns writes of the filter output into the capture RAM by compensating ROM and filter latency, then holds a readout address that the user steps up and down for seven-segment display. Sits between the debouncers, the sample ROM, the filter core and the capture RAM in the board top level.

## Interface
- DATA_BITS, 8, sample and result width
- ADDR_BITS, 8, ROM/RAM address width
- NUM_SAMPLES, 255, samples per run; 1 ≤ NUM_SAMPLES ≤ 2^ADDR_BITS
- ROM_LAT, 1, cycles from o_rom_addr to valid i_rom_data
- FILT_LAT, 1, cycles from o_filt_en to valid i_filt_out
- clk  in  1  single system clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  debounced level; rising edge requests a run
- continuous  in  1  1: restart automatically after DONE; sampled on entry to DONE
- step_up  in  1  debounced level; rising edge increments readout address
- step_down  in  1  debounced level; rising edge decrements readout address
- o_rom_addr  out  ADDR_BITS  sample ROM read address
- i_rom_data  in  DATA_BITS  sample ROM read data
- o_filt_clr  out  1  one-cycle synchronous clear of filter window
- o_filt_en  out  1  filter shift/compute enable
- o_filt_in  out  DATA_BITS  sample presented to filter (registered copy of i_rom_data)
- i_filt_out  in  DATA_BITS  filter result
- o_ram_we  out  1  capture RAM write enable
- o_ram_waddr  out  ADDR_BITS  capture RAM write address
- o_ram_wdata  out  DATA_BITS  capture RAM write data (= i_filt_out)
- o_rd_addr  out  ADDR_BITS  readout address to RAM read port and display
- busy  out  1  high in CLEAR, RUN, FLUSH
- done  out  1  high in DONE

## Operation
- States: IDLE, CLEAR, RUN, FLUSH, DONE. Reset → IDLE.
- IDLE: all strobes low. start rising edge → CLEAR.
- CLEAR: one cycle; o_filt_clr=1, read counter and write counter cleared → RUN.
- RUN: o_rom_addr = read counter, incremented every cycle; after issuing address NUM_SAMPLES-1 → FLUSH.
- Issue tracking: valid bit shift register of depth ROM_LAT+FILT_LAT; bit enters on every RUN cycle. Tap at ROM_LAT drives o_filt_en (o_filt_in registered in same cycle); final tap drives o_ram_we.
- Write counter increments on every o_ram_we; o_ram_waddr = write counter before increment; first write at address 0.
- FLUSH: no new issues; exits to DONE the cycle after last o_ram_we (write count = NUM_SAMPLES).
- DONE: done=1. If continuous=1 → CLEAR next cycle; else stays until start rising edge → CLEAR.
- start edges during CLEAR/RUN/FLUSH ignored (not queued).
- Readout: rising edges of step_up/step_down move o_rd_addr ±1 in any state; wraps NUM_SAMPLES-1 ↔ 0. Both edges same cycle: no change. o_rd_addr not changed by runs.
- Edge detection: one registered copy of each of start, step_up, step_down; edge = in & ~prev. prev registers reset to 1, so a level held high through reset produces no edge.

## Timing
- Reset values: all outputs 0, state IDLE, edge-detect registers 1.
- Start edge at cycle 0 (input sampled) → CLEAR cycle 1 → first o_rom_addr=0 cycle 2.
- First o_filt_en at cycle 2+ROM_LAT; first o_ram_we at cycle 2+ROM_LAT+FILT_LAT.
- RUN lasts exactly NUM_SAMPLES cycles; o_filt_en and o_ram_we each assert exactly NUM_SAMPLES contiguous cycles per run.
- done rises cycle 2+NUM_SAMPLES+ROM_LAT+FILT_LAT.
- Step edge sampled cycle k → o_rd_addr updated cycle k+1.
- rst low at any time: immediate return to reset values, in-flight valid bits discarded, no further writes.

## Structure
- Shared package: state enum encoding, clog2 helper, default latency constants shared with the top level.
- One natural sub-module: edge_detect (parametrised width, reset value 1), instantiated once for the three button inputs.
- Counters ADDR_BITS+1 wide internally so NUM_SAMPLES = 2^ADDR_BITS terminates correctly.

## Test plan
- Default params, start pulse → o_rom_addr 0..254 over 255 cycles, o_ram_we 255 cycles with waddr 0..254, o_ram_wdata matches model filter output at ROM_LAT+FILT_LAT delay, done at cycle 2+255+2=259.
- ROM_LAT=2, FILT_LAT=5, NUM_SAMPLES=16 → first write at cycle 9, last write waddr 15, done at cycle 25.
- step_down edge from reset → o_rd_addr=254; 255 step_up edges → back to 254; simultaneous up/down edges → unchanged.
- start held high through reset release → no run; start edge mid-RUN → ignored, write count still 255.
- continuous=1 → CLEAR one cycle after DONE, o_filt_clr pulses each run, waddr restarts at 0.
- rst asserted mid-RUN at sample 100 → all outputs 0 immediately, no o_ram_we after release until new start edge.
